mc_control_unit: RTL and testbench
==================================

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter MEM_WAIT, default 1: 1 = FETCH/MEM_RD/MEM_WR hold until mem_ready; 0 = mem_ready ignored, one cycle each.
REQ-002 Parameter RA_REG, default 31: register index driven on ra_idx for JAL writeback.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 opcode  input  6  instruction opcode from instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory access complete.
REQ-008 pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a  output  1 each  standard multicycle datapath controls.
REQ-009 reg_dst  output  2  00 rt, 01 rd, 10 RA_REG.
REQ-010 mem_to_reg  output  2  00 ALUOut, 01 MDR, 10 PC.
REQ-011 alu_src_b  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-012 alu_op  output  3  000 add, 001 sub, 010 funct, 011 or, 100 lui, 101 addu.
REQ-013 pc_source  output  2  00 ALU, 01 ALUOut, 10 jump target.
REQ-014 ra_idx  output  5  constant RA_REG.
REQ-015 state  output  4  current state encoding; illegal  output  1  sticky unsupported-opcode flag.

Function
REQ-016 States/encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, JAL 12, TRAP 13.
REQ-017 Outputs Moore-decoded from state only, except pc_write in FETCH and ir_write gated by mem_ready when MEM_WAIT=1.
REQ-018 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00; ir_write=pc_write=ready; -> DECODE when ready (ready = mem_ready or MEM_WAIT=0).
REQ-019 DECODE: alu_src_a=0, alu_src_b=11, alu_op=000; dispatch: 000000->R_EXEC, 100011/101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP, 000011->JAL, 001111/001101/001000/001001->I_EXEC, other->TRAP.
REQ-020 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000; -> MEM_RD if LW else MEM_WR.
REQ-021 MEM_RD: mem_read=1, iord=1; -> MEM_WB when ready. MEM_WR: mem_write=1, iord=1; -> FETCH when ready.
REQ-022 MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01; -> FETCH.
REQ-023 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010 -> R_WB: reg_write=1, reg_dst=01, mem_to_reg=00 -> FETCH.
REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01; PC updates iff zero=1; -> FETCH.
REQ-025 JUMP: pc_write=1, pc_source=10; -> FETCH.
REQ-026 JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10 (PC+4 already in PC); -> FETCH; single cycle.
REQ-027 I_EXEC: alu_src_a=1, alu_src_b=10, alu_op per opcode: LUI 100, ORI 011, ADDI 000, ADDIU 101 (opcode latched in DECODE; opcode may change after) -> I_WB: reg_write=1, reg_dst=00, mem_to_reg=00 -> FETCH.
REQ-028 TRAP: all write enables 0, illegal=1; remains in TRAP until reset.
REQ-029 All signals not listed for a state are 0/00/000.
REQ-030 Cycle counts with ready=1: R/I-type 4, LW 5, SW 4, BEQ 3, J 3, JAL 3.
REQ-031 MEM_WAIT=1, mem_ready low: state and all outputs held stable; no write enable asserts more than one cycle per access.

Reset
REQ-032 rst_n low asynchronously forces state=FETCH, latched opcode=0, illegal=0, all write enables 0 within the same time step, including mid-MEM_WR.
REQ-033 First FETCH after rst_n deassertion begins at the next rising edge.

Structure
REQ-034 State encodings, alu_op codes, opcode constants, and mux-select codes reside in shared package mips_ctrl_pkg.
REQ-035 One sub-module, mc_ctrl_decode: combinational state-to-output decode; next-state logic and registers in mc_control_unit.

Verification
REQ-036 ADD (000000), mem_ready=1 -> states 0,1,6,7,0; R_WB reg_write=1, reg_dst=01.
REQ-037 LW (100011), mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, mem_read stable, then MEM_WB mem_to_reg=01.
REQ-038 BEQ with zero=0 and zero=1 -> pc_write_cond=1 in BRANCH, pc_source=01, 3-cycle instruction.
REQ-039 JAL (000011) -> JAL state: pc_write=1, reg_write=1, reg_dst=10, ra_idx=31.
REQ-040 ORI (001101) then LUI (001111) -> I_EXEC alu_op 011 then 100; opcode 111111 -> TRAP, illegal=1 sticky.
REQ-041 rst_n low during MEM_WR -> mem_write drops immediately, state=0; MEM_WAIT=0 build: FETCH lasts 1 cycle with mem_ready=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes,
// opcode constants, ALU operation codes and datapath mux select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_R_EXEC   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JUMP     = 4'd9,
        ST_I_EXEC   = 4'd10,
        ST_I_WB     = 4'd11,
        ST_JAL      = 4'd12,
        ST_TRAP     = 4'd13
    } ctrlStateT;

    // Instruction opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_LUI   = 3'b100;
    localparam logic [2:0] ALU_ADDU  = 3'b101;

    // Register file destination select
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // Register file write-data select
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Execution state entered from DECODE for a given opcode
    function automatic ctrlStateT dispatchState(input logic [5:0] op);
        ctrlStateT st;
        case (op)
            OP_RTYPE:                          st = ST_R_EXEC;
            OP_LW, OP_SW:                      st = ST_MEM_ADDR;
            OP_BEQ:                            st = ST_BRANCH;
            OP_J:                              st = ST_JUMP;
            OP_JAL:                            st = ST_JAL;
            OP_LUI, OP_ORI, OP_ADDI, OP_ADDIU: st = ST_I_EXEC;
            default:                           st = ST_TRAP;
        endcase
        return st;
    endfunction

    // ALU operation for an immediate-type instruction
    function automatic logic [2:0] immAluOp(input logic [5:0] op);
        logic [2:0] aop;
        case (op)
            OP_LUI:   aop = ALU_LUI;
            OP_ORI:   aop = ALU_OR;
            OP_ADDI:  aop = ALU_ADD;
            OP_ADDIU: aop = ALU_ADDU;
            default:  aop = ALU_ADD;
        endcase
        return aop;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control decode for the multicycle control unit.
// Everything is a function of the current state, except the FETCH write
// strobes which follow the memory-ready qualifier.
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] latchedOp,
    input  logic       ready,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iord,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] regDst,
    output logic [1:0] memToReg,
    output logic [1:0] aluSrcB,
    output logic [2:0] aluOp,
    output logic [1:0] pcSource
);

    // Per-state control word; anything a state does not name stays zero
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iord        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        regDst      = REGDST_RT;
        memToReg    = M2R_ALUOUT;
        aluSrcB     = SRCB_B;
        aluOp       = ALU_ADD;
        pcSource    = PCSRC_ALU;
        case (state)
            ST_FETCH: begin
                memRead = 1'b1;
                aluSrcB = SRCB_FOUR;
                irWrite = ready;
                pcWrite = ready;
            end
            ST_DECODE: begin
                aluSrcB = SRCB_IMMSH2;
            end
            ST_MEM_ADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
            end
            ST_MEM_RD: begin
                memRead = 1'b1;
                iord    = 1'b1;
            end
            ST_MEM_WB: begin
                regWrite = 1'b1;
                regDst   = REGDST_RT;
                memToReg = M2R_MDR;
            end
            ST_MEM_WR: begin
                memWrite = 1'b1;
                iord     = 1'b1;
            end
            ST_R_EXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_B;
                aluOp   = ALU_FUNCT;
            end
            ST_R_WB: begin
                regWrite = 1'b1;
                regDst   = REGDST_RD;
                memToReg = M2R_ALUOUT;
            end
            ST_BRANCH: begin
                aluSrcA     = 1'b1;
                aluSrcB     = SRCB_B;
                aluOp       = ALU_SUB;
                pcWriteCond = 1'b1;
                pcSource    = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = PCSRC_JUMP;
            end
            ST_I_EXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
                aluOp   = immAluOp(latchedOp);
            end
            ST_I_WB: begin
                regWrite = 1'b1;
                regDst   = REGDST_RT;
                memToReg = M2R_ALUOUT;
            end
            ST_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value
                pcWrite  = 1'b1;
                pcSource = PCSRC_JUMP;
                regWrite = 1'b1;
                regDst   = REGDST_RA;
                memToReg = M2R_PC;
            end
            ST_TRAP: begin
                pcWrite = 1'b0;
            end
            default: begin
                pcWrite = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control unit: state register, opcode latch, sticky
// illegal-opcode flag and next-state logic. Control outputs are decoded
// from the state by mc_ctrl_decode; write strobes are forced low while
// reset is asserted.
module mc_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 32'd1,
    parameter int unsigned RA_REG   = 32'd31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic [4:0] ra_idx,
    output logic [3:0] state,
    output logic       illegal
);

    localparam logic [4:0] RA_IDX = 5'(RA_REG);

    ctrlStateT  state_r;
    ctrlStateT  nextState_s;
    logic [5:0] latchedOp_r;
    logic       illegal_r;
    logic       ready_s;

    logic       pcWrite_s;
    logic       pcWriteCond_s;
    logic       memWrite_s;
    logic       irWrite_s;
    logic       regWrite_s;

    // The branch decision (pc_write_cond & zero) is made in the datapath
    logic       unusedZero_s;
    assign unusedZero_s = zero;

    // Without wait states every memory access completes in one cycle
    assign ready_s = (MEM_WAIT == 32'd0) ? 1'b1 : mem_ready;

    // Next-state selection
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (ready_s) begin
                    nextState_s = ST_DECODE;
                end else begin
                    nextState_s = ST_FETCH;
                end
            end
            ST_DECODE:   nextState_s = dispatchState(opcode);
            ST_MEM_ADDR: begin
                if (latchedOp_r == OP_LW) begin
                    nextState_s = ST_MEM_RD;
                end else begin
                    nextState_s = ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                if (ready_s) begin
                    nextState_s = ST_MEM_WB;
                end else begin
                    nextState_s = ST_MEM_RD;
                end
            end
            ST_MEM_WR: begin
                if (ready_s) begin
                    nextState_s = ST_FETCH;
                end else begin
                    nextState_s = ST_MEM_WR;
                end
            end
            ST_MEM_WB:   nextState_s = ST_FETCH;
            ST_R_EXEC:   nextState_s = ST_R_WB;
            ST_R_WB:     nextState_s = ST_FETCH;
            ST_BRANCH:   nextState_s = ST_FETCH;
            ST_JUMP:     nextState_s = ST_FETCH;
            ST_I_EXEC:   nextState_s = ST_I_WB;
            ST_I_WB:     nextState_s = ST_FETCH;
            ST_JAL:      nextState_s = ST_FETCH;
            ST_TRAP:     nextState_s = ST_TRAP;
            // Unassigned encodings can only come from an upset: park in TRAP
            default:     nextState_s = ST_TRAP;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Opcode is captured in DECODE so later states ignore IR changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latchedOp_r <= 6'b000000;
        end else if (state_r == ST_DECODE) begin
            latchedOp_r <= opcode;
        end else begin
            latchedOp_r <= latchedOp_r;
        end
    end

    // Sticky flag raised together with entry into TRAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= illegal_r | (nextState_s == ST_TRAP);
        end
    end

    mc_ctrl_decode u_decode (
        .state       (state_r),
        .latchedOp   (latchedOp_r),
        .ready       (ready_s),
        .pcWrite     (pcWrite_s),
        .pcWriteCond (pcWriteCond_s),
        .iord        (iord),
        .memRead     (mem_read),
        .memWrite    (memWrite_s),
        .irWrite     (irWrite_s),
        .regWrite    (regWrite_s),
        .aluSrcA     (alu_src_a),
        .regDst      (reg_dst),
        .memToReg    (mem_to_reg),
        .aluSrcB     (alu_src_b),
        .aluOp       (alu_op),
        .pcSource    (pc_source)
    );

    // Write strobes drop in the same time step as reset assertion
    assign pc_write      = pcWrite_s     & rst_n;
    assign pc_write_cond = pcWriteCond_s & rst_n;
    assign mem_write     = memWrite_s    & rst_n;
    assign ir_write      = irWrite_s     & rst_n;
    assign reg_write     = regWrite_s    & rst_n;

    assign ra_idx  = RA_IDX;
    assign state   = state_r;
    assign illegal = illegal_r;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: a queue-based instruction model predicts the
// state and control word every cycle under random opcodes, memory stalls
// and resets; directed sequences pin the model with literal expectations.
`timescale 1ns/1ps
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write;
    logic       ir_write, reg_write, alu_src_a, illegal;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [4:0] ra_idx;
    logic [3:0] state;

    // Second instance built without memory wait states
    logic [5:0] opcodeN;
    logic       memReadyN;
    logic       nPcWrite, nPcWriteCond, nIord, nMemRead, nMemWrite;
    logic       nIrWrite, nRegWrite, nAluSrcA, nIllegal;
    logic [1:0] nRegDst, nMemToReg, nAluSrcB, nPcSource;
    logic [2:0] nAluOp;
    logic [4:0] nRaIdx;
    logic [3:0] nState;

    int checks = 0;
    int errors = 0;

    int         q[$];
    logic [2:0] iAluOp = 3'd0;
    bit         modelOn = 1'b0;

    logic [5:0] legal [10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02,
                               6'h03, 6'h0F, 6'h0D, 6'h08, 6'h09};

    always #5 clk = ~clk;

    mc_control_unit #(.MEM_WAIT(32'd1), .RA_REG(32'd31)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .ra_idx(ra_idx), .state(state), .illegal(illegal)
    );

    mc_control_unit #(.MEM_WAIT(32'd0), .RA_REG(32'd31)) dutNoWait (
        .clk(clk), .rst_n(rst_n), .opcode(opcodeN), .zero(zero), .mem_ready(memReadyN),
        .pc_write(nPcWrite), .pc_write_cond(nPcWriteCond), .iord(nIord),
        .mem_read(nMemRead), .mem_write(nMemWrite), .ir_write(nIrWrite),
        .reg_write(nRegWrite), .alu_src_a(nAluSrcA), .reg_dst(nRegDst),
        .mem_to_reg(nMemToReg), .alu_src_b(nAluSrcB), .alu_op(nAluOp),
        .pc_source(nPcSource), .ra_idx(nRaIdx), .state(nState), .illegal(nIllegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] actCtl();
        return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write,
                alu_src_a, reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source};
    endfunction

    // Control word the datapath needs in each step of an instruction
    function automatic logic [18:0] expCtl(input int s, input logic rdy,
                                           input logic [2:0] iop, input logic rstLow);
        logic pw, pwc, iod, mr, mw, iw, rw, asa;
        logic [1:0] rd, m2r, asb, pcs;
        logic [2:0] aop;
        {pw, pwc, iod, mr, mw, iw, rw, asa} = 8'd0;
        rd = 2'd0; m2r = 2'd0; asb = 2'd0; pcs = 2'd0; aop = 3'd0;
        case (s)
            0:  begin mr = 1'b1; asb = 2'd1; iw = rdy; pw = rdy; end
            1:  asb = 2'd3;
            2:  begin asa = 1'b1; asb = 2'd2; end
            3:  begin mr = 1'b1; iod = 1'b1; end
            4:  begin rw = 1'b1; m2r = 2'd1; end
            5:  begin mw = 1'b1; iod = 1'b1; end
            6:  begin asa = 1'b1; aop = 3'd2; end
            7:  begin rw = 1'b1; rd = 2'd1; end
            8:  begin asa = 1'b1; aop = 3'd1; pwc = 1'b1; pcs = 2'd1; end
            9:  begin pw = 1'b1; pcs = 2'd2; end
            10: begin asa = 1'b1; asb = 2'd2; aop = iop; end
            11: rw = 1'b1;
            12: begin pw = 1'b1; pcs = 2'd2; rw = 1'b1; rd = 2'd2; m2r = 2'd2; end
            default: pw = 1'b0;
        endcase
        if (rstLow) begin
            pw = 1'b0; pwc = 1'b0; mw = 1'b0; iw = 1'b0; rw = 1'b0;
        end
        return {pw, pwc, iod, mr, mw, iw, rw, asa, rd, m2r, asb, aop, pcs};
    endfunction

    // Compare against the model mid-cycle, then step the model
    always @(negedge clk) begin
        int h;
        if (modelOn) begin
            if (!rst_n) begin
                chk("rst_state", 32'(state), 32'd0);
                chk("rst_ctl", 32'(actCtl()), 32'(expCtl(0, mem_ready, 3'd0, 1'b1)));
                chk("rst_illegal", 32'(illegal), 32'd0);
                q.delete();
                q.push_back(0);
            end else begin
                h = q[0];
                chk("state", 32'(state), 32'(h));
                chk("ctl", 32'(actCtl()), 32'(expCtl(h, mem_ready, iAluOp, 1'b0)));
                chk("illegal", 32'(illegal), (h == 13) ? 32'd1 : 32'd0);
                chk("ra_idx", 32'(ra_idx), 32'd31);
                if (h == 13) begin
                    h = 13;
                end else if ((h == 0 || h == 3 || h == 5) && !mem_ready) begin
                    h = h;
                end else begin
                    void'(q.pop_front());
                    if (h == 0) begin
                        q.push_back(1);
                    end else if (h == 1) begin
                        case (opcode)
                            6'h00: begin q.push_back(6); q.push_back(7); end
                            6'h23: begin q.push_back(2); q.push_back(3); q.push_back(4); end
                            6'h2B: begin q.push_back(2); q.push_back(5); end
                            6'h04: q.push_back(8);
                            6'h02: q.push_back(9);
                            6'h03: q.push_back(12);
                            6'h0F: begin iAluOp = 3'd4; q.push_back(10); q.push_back(11); end
                            6'h0D: begin iAluOp = 3'd3; q.push_back(10); q.push_back(11); end
                            6'h08: begin iAluOp = 3'd0; q.push_back(10); q.push_back(11); end
                            6'h09: begin iAluOp = 3'd5; q.push_back(10); q.push_back(11); end
                            default: q.push_back(13);
                        endcase
                    end
                    if (q.size() == 0) q.push_back(0);
                end
            end
        end
    end

    task automatic cyc(input logic [5:0] op, input logic mr);
        @(posedge clk);
        #1;
        opcode    = op;
        mem_ready = mr;
        #1;
    endtask

    initial begin
        rst_n = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b0;
        opcodeN = 6'h00; memReadyN = 1'b0;
        q.push_back(0);
        modelOn = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        chk("reset_pcw", 32'(nPcWrite), 32'd0);
        repeat (3) @(posedge clk);
        @(posedge clk); #1; rst_n = 1'b1; #1;

        // No-wait build: FETCH completes in one cycle although mem_ready is low
        chk("nw_fetch", 32'(nState), 32'd0);
        chk("nw_irw", 32'(nIrWrite), 32'd1);
        chk("nw_pcw", 32'(nPcWrite), 32'd1);
        cyc(6'h00, 1'b0); chk("nw_decode", 32'(nState), 32'd1);
        chk("held_fetch", 32'(state), 32'd0);
        cyc(6'h00, 1'b0); chk("nw_rexec", 32'(nState), 32'd6);
        cyc(6'h00, 1'b0); chk("nw_rwb", 32'(nState), 32'd7);
        cyc(6'h00, 1'b0); chk("nw_back", 32'(nState), 32'd0);

        // ADD: 0,1,6,7,0
        cyc(6'h00, 1'b1); chk("add_s0", 32'(state), 32'd0); chk("add_pcw", 32'(pc_write), 32'd1);
        cyc(6'h00, 1'b1); chk("add_s1", 32'(state), 32'd1);
        cyc(6'h3F, 1'b1); chk("add_s6", 32'(state), 32'd6); chk("add_aluop", 32'(alu_op), 32'd2);
        cyc(6'h3F, 1'b1); chk("add_s7", 32'(state), 32'd7);
        chk("add_rw", 32'(reg_write), 32'd1); chk("add_rd", 32'(reg_dst), 32'd1);
        cyc(6'h3F, 1'b1); chk("add_s0b", 32'(state), 32'd0);

        // LW with three stall cycles in MEM_RD
        cyc(6'h23, 1'b1); chk("lw_s1", 32'(state), 32'd1);
        cyc(6'h3F, 1'b1); chk("lw_s2", 32'(state), 32'd2);
        for (int i = 0; i < 4; i++) begin
            cyc(6'h3F, (i == 3) ? 1'b1 : 1'b0);
            chk("lw_memrd", 32'(state), 32'd3);
            chk("lw_mr", 32'(mem_read), 32'd1);
        end
        cyc(6'h3F, 1'b1); chk("lw_s4", 32'(state), 32'd4); chk("lw_m2r", 32'(mem_to_reg), 32'd1);
        cyc(6'h3F, 1'b1); chk("lw_s0", 32'(state), 32'd0);

        // BEQ with zero low then high
        for (int z = 0; z < 2; z++) begin
            zero = z[0];
            cyc(6'h04, 1'b1); chk("beq_s1", 32'(state), 32'd1);
            cyc(6'h3F, 1'b1); chk("beq_s8", 32'(state), 32'd8);
            chk("beq_pwc", 32'(pc_write_cond), 32'd1); chk("beq_pcs", 32'(pc_source), 32'd1);
            cyc(6'h3F, 1'b1); chk("beq_s0", 32'(state), 32'd0);
        end

        // JAL
        cyc(6'h03, 1'b1); chk("jal_s1", 32'(state), 32'd1);
        cyc(6'h3F, 1'b1); chk("jal_s12", 32'(state), 32'd12);
        chk("jal_pcw", 32'(pc_write), 32'd1); chk("jal_rw", 32'(reg_write), 32'd1);
        chk("jal_rd", 32'(reg_dst), 32'd2); chk("jal_ra", 32'(ra_idx), 32'd31);
        cyc(6'h3F, 1'b1); chk("jal_s0", 32'(state), 32'd0);

        // ORI then LUI, opcode changed after DECODE
        cyc(6'h0D, 1'b1); chk("ori_s1", 32'(state), 32'd1);
        cyc(6'h0F, 1'b1); chk("ori_s10", 32'(state), 32'd10); chk("ori_aluop", 32'(alu_op), 32'd3);
        cyc(6'h0F, 1'b1); chk("ori_s11", 32'(state), 32'd11);
        cyc(6'h0F, 1'b1); chk("ori_s0", 32'(state), 32'd0);
        cyc(6'h0F, 1'b1); chk("lui_s1", 32'(state), 32'd1);
        cyc(6'h0D, 1'b1); chk("lui_s10", 32'(state), 32'd10); chk("lui_aluop", 32'(alu_op), 32'd4);
        cyc(6'h0D, 1'b1); chk("lui_s11", 32'(state), 32'd11);
        cyc(6'h0D, 1'b1); chk("lui_s0", 32'(state), 32'd0);

        // SW stalled in MEM_WR, then asynchronous reset
        cyc(6'h2B, 1'b1); chk("sw_s1", 32'(state), 32'd1);
        cyc(6'h3F, 1'b1); chk("sw_s2", 32'(state), 32'd2);
        cyc(6'h3F, 1'b0); chk("sw_s5", 32'(state), 32'd5); chk("sw_mw", 32'(mem_write), 32'd1);
        @(posedge clk); #1; rst_n = 1'b0; #1;
        chk("swrst_state", 32'(state), 32'd0); chk("swrst_mw", 32'(mem_write), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1; mem_ready = 1'b1; #1;
        chk("post_rst", 32'(state), 32'd0);

        // Unsupported opcode traps and stays trapped
        cyc(6'h3F, 1'b1); chk("trap_s1", 32'(state), 32'd1);
        cyc(6'h00, 1'b1); chk("trap_s13", 32'(state), 32'd13); chk("trap_ill", 32'(illegal), 32'd1);
        cyc(6'h00, 1'b1); chk("trap_hold", 32'(state), 32'd13); chk("trap_sticky", 32'(illegal), 32'd1);
        chk("trap_pcw", 32'(pc_write), 32'd0);

        // Random opcodes, stalls and resets against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 9) < 9) opcode = legal[$urandom_range(0, 9)];
            else opcode = 6'($urandom_range(0, 63));
            mem_ready = ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0;
            zero      = 1'($urandom_range(0, 1));
            rst_n     = ($urandom_range(0, 39) != 0) ? 1'b1 : 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        modelOn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
